// File: rtl/pll_lock_monitor.sv
// PLL lock and per-channel frequency monitor: arm/settle/measure sequencing,
// windowed edge counting against min/max limits, saturating error statistics.
`timescale 1ns/100ps
module pll_lock_monitor #(
    parameter int NUM_CLK       = 5,
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SYNC_STAGES   = 3,
    parameter int ERR_W         = 3
) (
    input  logic                     clk_tb,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear_err,
    input  logic                     pll_lock,
    input  logic [NUM_CLK-1:0]       clk_mon,
    input  logic [NUM_CLK*CNT_W-1:0] exp_min,
    input  logic [NUM_CLK*CNT_W-1:0] exp_max,
    output logic [2:0]               state,
    output logic                     lock_ok,
    output logic                     meas_valid,
    output logic [NUM_CLK*CNT_W-1:0] freq_cnt,
    output logic [NUM_CLK-1:0]       freq_err,
    output logic                     timeout_err,
    output logic [ERR_W-1:0]         lock_lost_cnt,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     err_flag
);

    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WIN_W = $clog2(WIN_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        MEASURE   = 3'd3
    } state_t;

    state_t cur, nxt;

    logic [SYNC_STAGES-1:0]              lock_sync;
    logic                                lock_s;
    logic [NUM_CLK-1:0][SYNC_STAGES-1:0] mon_sync;
    logic [NUM_CLK-1:0]                  mon_hist;
    logic [NUM_CLK-1:0]                  mon_edge;

    logic [TMR_W-1:0] tmr;
    logic [SET_W-1:0] settle;
    logic [WIN_W-1:0] win;

    logic [NUM_CLK-1:0][CNT_W-1:0] edge_cnt;
    logic [NUM_CLK-1:0][CNT_W-1:0] cnt_upd;
    logic [NUM_CLK-1:0][CNT_W-1:0] freq_cnt_q;
    logic [NUM_CLK-1:0]            err_vec;

    logic tmr_clr, settle_clr, meas_clr, win_end, timeout_ev, lost_ev;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
            mon_sync  <= '0;
            mon_hist  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
            for (int unsigned i = 0; i < NUM_CLK; i++) begin
                mon_sync[i] <= {mon_sync[i][SYNC_STAGES-2:0], clk_mon[i]};
                mon_hist[i] <= mon_sync[i][SYNC_STAGES-1];
            end
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Count including any edge seen this cycle, so the window's last cycle is not lost.
    always_comb begin
        cnt_upd = edge_cnt;
        err_vec = '0;
        mon_edge = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            mon_edge[i] = mon_sync[i][SYNC_STAGES-1] & ~mon_hist[i];
            if (mon_edge[i] && (edge_cnt[i] != '1))
                cnt_upd[i] = edge_cnt[i] + 1'b1;
            err_vec[i] = (cnt_upd[i] < exp_min[i*CNT_W +: CNT_W]) ||
                         (cnt_upd[i] > exp_max[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt        = cur;
        tmr_clr    = 1'b0;
        settle_clr = 1'b0;
        meas_clr   = 1'b0;
        win_end    = 1'b0;
        timeout_ev = 1'b0;
        lost_ev    = 1'b0;
        case (cur)
            IDLE: begin
                if (start) begin
                    nxt     = WAIT_LOCK;
                    tmr_clr = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt        = SETTLE;
                    settle_clr = 1'b1;
                end else if (tmr == TMR_LAST) begin
                    nxt        = IDLE;
                    timeout_ev = 1'b1;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    nxt = WAIT_LOCK;
                end else if (settle == SET_LAST) begin
                    nxt      = MEASURE;
                    meas_clr = 1'b1;
                end
            end
            MEASURE: begin
                if (!lock_s) begin
                    nxt     = WAIT_LOCK;
                    tmr_clr = 1'b1;
                    lost_ev = 1'b1;
                end else if (win == WIN_LAST) begin
                    win_end = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        // stop overrides everything and suppresses any error or result in its cycle
        if (stop) begin
            nxt        = IDLE;
            win_end    = 1'b0;
            timeout_ev = 1'b0;
            lost_ev    = 1'b0;
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            tmr      <= '0;
            settle   <= '0;
            win      <= '0;
            edge_cnt <= '0;
        end else begin
            if (tmr_clr)
                tmr <= '0;
            else if (cur == WAIT_LOCK && tmr != TMR_LAST)
                tmr <= tmr + 1'b1;

            if (settle_clr)
                settle <= '0;
            else if (cur == SETTLE && lock_s && settle != SET_LAST)
                settle <= settle + 1'b1;

            if (meas_clr || win_end) begin
                win      <= '0;
                edge_cnt <= '0;
            end else if (cur == MEASURE) begin
                win      <= win + 1'b1;
                edge_cnt <= cnt_upd;
            end
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid    <= 1'b0;
            freq_cnt_q    <= '0;
            freq_err      <= '0;
            timeout_err   <= 1'b0;
            lock_lost_cnt <= '0;
            err_cnt       <= '0;
        end else begin
            meas_valid <= win_end;
            if (win_end) begin
                freq_cnt_q <= cnt_upd;
                freq_err   <= err_vec;
            end
            if (clear_err) begin
                timeout_err   <= 1'b0;
                lock_lost_cnt <= '0;
                err_cnt       <= '0;
            end else begin
                if (timeout_ev)
                    timeout_err <= 1'b1;
                if (lost_ev && lock_lost_cnt != '1)
                    lock_lost_cnt <= lock_lost_cnt + 1'b1;
                if ((timeout_ev || lost_ev || (win_end && |err_vec)) && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign state    = cur;
    assign lock_ok  = (cur == MEASURE);
    assign freq_cnt = freq_cnt_q;
    assign err_flag = |err_cnt;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: two monitored clocks, short window,
// hand-computed latencies, counts and error statistics.
`timescale 1ns/100ps
module tb_pll_lock_monitor;

    localparam int NUM_CLK = 2;
    localparam int CNT_W   = 16;
    localparam int ERR_W   = 3;

    logic                     clk_tb = 1'b0;
    logic                     rst_n;
    logic                     start, stop, clear_err, pll_lock;
    logic                     m0 = 1'b0;
    logic                     m1 = 1'b0;
    logic [NUM_CLK-1:0]       clk_mon;
    logic [NUM_CLK*CNT_W-1:0] exp_min, exp_max;
    logic [2:0]               state;
    logic                     lock_ok, meas_valid;
    logic [NUM_CLK*CNT_W-1:0] freq_cnt;
    logic [NUM_CLK-1:0]       freq_err;
    logic                     timeout_err;
    logic [ERR_W-1:0]         lock_lost_cnt, err_cnt;
    logic                     err_flag;

    realtime half1 = 20.0;
    int n_vec = 0;
    int n_bad = 0;

    assign clk_mon = {m1, m0};
    assign exp_min = {16'd4, 16'd9};
    assign exp_max = {16'd6, 16'd11};

    pll_lock_monitor #(
        .NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .WIN_CYCLES(100), .SETTLE_CYCLES(8),
        .LOCK_TIMEOUT(500), .SYNC_STAGES(3), .ERR_W(ERR_W)
    ) dut (
        .clk_tb(clk_tb), .rst_n(rst_n), .start(start), .stop(stop),
        .clear_err(clear_err), .pll_lock(pll_lock), .clk_mon(clk_mon),
        .exp_min(exp_min), .exp_max(exp_max), .state(state), .lock_ok(lock_ok),
        .meas_valid(meas_valid), .freq_cnt(freq_cnt), .freq_err(freq_err),
        .timeout_err(timeout_err), .lock_lost_cnt(lock_lost_cnt),
        .err_cnt(err_cnt), .err_flag(err_flag)
    );

    // clk_tb edges on odd ns; monitored clocks toggle on x.5 ns to stay off them
    always #1 clk_tb = ~clk_tb;
    initial begin #0.5; forever #10 m0 = ~m0; end
    initial begin #0.5; forever #(half1) m1 = ~m1; end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        do begin @(negedge clk_tb); n++; end while (!meas_valid && n < max_cyc);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, output int n);
        n = 0;
        do begin @(negedge clk_tb); n++; end while (state != s && n < max_cyc);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk_tb); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1; @(negedge clk_tb); clear_err = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"}, 32'(state), 0);
        check({pfx, "_lock_ok"}, 32'(lock_ok), 0);
        check({pfx, "_meas_valid"}, 32'(meas_valid), 0);
        check({pfx, "_freq_cnt"}, freq_cnt, 0);
        check({pfx, "_freq_err"}, 32'(freq_err), 0);
        check({pfx, "_timeout_err"}, 32'(timeout_err), 0);
        check({pfx, "_lock_lost"}, 32'(lock_lost_cnt), 0);
        check({pfx, "_err_cnt"}, 32'(err_cnt), 0);
        check({pfx, "_err_flag"}, 32'(err_flag), 0);
    endtask

    initial begin
        int n, nv;
        logic saw_wait, saw_settle;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear_err = 1'b0; pll_lock = 1'b0;
        repeat (5) @(negedge clk_tb);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_tb);

        // nominal: arm, lock later, 3 sync + 1 + 8 settle cycles to MEASURE
        pulse_start();
        check("arm_state", 32'(state), 1);
        while ($realtime < 100.0) @(negedge clk_tb);
        pll_lock = 1'b1;
        wait_state(3'd3, 40, n);
        check("lock_to_measure_cycles", n, 12);
        check("lock_ok", 32'(lock_ok), 1);
        wait_valid(150, n);
        check("first_window_cycles", n, 100);
        check("nom_cnt0", 32'(freq_cnt[15:0]), 10);
        check("nom_cnt1", 32'(freq_cnt[31:16]), 5);
        check("nom_freq_err", 32'(freq_err), 0);
        check("nom_err_cnt", 32'(err_cnt), 0);
        @(negedge clk_tb);
        check("meas_valid_width", 32'(meas_valid), 0);
        wait_valid(150, n);
        check("window_period", n, 99);
        pulse_start();
        check("start_in_measure", 32'(state), 3);

        // lock loss mid-window: discard window, go around WAIT_LOCK/SETTLE
        repeat (30) @(negedge clk_tb);
        nv = 0; saw_wait = 1'b0; saw_settle = 1'b0;
        for (int i = 0; i < 115; i++) begin
            if (i == 0)  pll_lock = 1'b0;
            if (i == 10) pll_lock = 1'b1;
            @(negedge clk_tb);
            nv += int'(meas_valid);
            if (state == 3'd1) saw_wait = 1'b1;
            if (state == 3'd2) saw_settle = 1'b1;
        end
        check("loss_no_valid", nv, 0);
        check("loss_saw_wait", 32'(saw_wait), 1);
        check("loss_saw_settle", 32'(saw_settle), 1);
        check("loss_back_measure", 32'(state), 3);
        check("loss_lost_cnt", 32'(lock_lost_cnt), 1);
        check("loss_err_cnt", 32'(err_cnt), 1);
        wait_valid(150, n);
        check("loss_next_valid_cycles", n, 7);
        check("loss_cnt0", 32'(freq_cnt[15:0]), 10);
        check("loss_cnt1", 32'(freq_cnt[31:16]), 5);

        pulse_clear();
        check("clr_err_cnt", 32'(err_cnt), 0);
        check("clr_lost_cnt", 32'(lock_lost_cnt), 0);

        // frequency fault on channel 1
        half1 = 10.0;
        wait_valid(150, n);
        pulse_clear();
        check("fault_clr_err", 32'(err_cnt), 0);
        for (int k = 1; k <= 8; k++) begin
            wait_valid(150, n);
            check($sformatf("fault_err_cnt_w%0d", k), 32'(err_cnt), (k > 7) ? 7 : k);
            if (k == 1) begin
                check("fault_cnt1", 32'(freq_cnt[31:16]), 10);
                check("fault_cnt0", 32'(freq_cnt[15:0]), 10);
                check("fault_freq_err", 32'(freq_err), 2);
                check("fault_err_flag", 32'(err_flag), 1);
            end
        end
        // clear_err in the same cycle as a failing window's increment
        repeat (99) @(negedge clk_tb);
        clear_err = 1'b1;
        @(negedge clk_tb);
        clear_err = 1'b0;
        check("coinc_meas_valid", 32'(meas_valid), 1);
        check("coinc_err_cnt", 32'(err_cnt), 0);
        check("coinc_freq_err_kept", 32'(freq_err), 2);
        stop = 1'b1; @(negedge clk_tb); stop = 1'b0;
        check("stop_measure_state", 32'(state), 0);
        check("stop_no_err", 32'(err_cnt), 0);
        half1 = 20.0;

        // lock timeout
        pll_lock = 1'b0;
        repeat (6) @(negedge clk_tb);
        pulse_start();
        n = 1;
        while (state != 3'd0 && n < 600) begin @(negedge clk_tb); n++; end
        check("timeout_cycles", n, 501);
        check("timeout_err", 32'(timeout_err), 1);
        check("timeout_err_cnt", 32'(err_cnt), 1);
        check("timeout_err_flag", 32'(err_flag), 1);
        pulse_clear();
        check("tclr_timeout_err", 32'(timeout_err), 0);
        check("tclr_err_cnt", 32'(err_cnt), 0);
        check("tclr_err_flag", 32'(err_flag), 0);

        // stop while settling
        pll_lock = 1'b1;
        repeat (6) @(negedge clk_tb);
        pulse_start();
        wait_state(3'd2, 10, n);
        check("reach_settle", 32'(state), 2);
        stop = 1'b1; @(negedge clk_tb); stop = 1'b0;
        check("stop_settle_state", 32'(state), 0);

        // asynchronous reset mid-window with non-zero statistics
        pulse_start();
        wait_state(3'd3, 40, n);
        check("rearm_measure", 32'(state), 3);
        pll_lock = 1'b0;
        repeat (10) @(negedge clk_tb);
        pll_lock = 1'b1;
        wait_state(3'd3, 60, n);
        check("pre_rst_lost_cnt", 32'(lock_lost_cnt), 1);
        wait_valid(150, n);
        check("pre_rst_valid", 32'(meas_valid), 1);
        repeat (40) @(negedge clk_tb);
        #0.3 rst_n = 1'b0;
        #0.2 check_reset("async_rst");
        @(negedge clk_tb);
        rst_n = 1'b1;
        @(negedge clk_tb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
